// File: rtl/display_7seg_mux.sv
// display_7seg_mux: multiplexed 7-segment driver with a sequential
// double-dabble binary-to-BCD converter.
//  - The scan timer steps through N_DIGITS digits, holding each one for
//    REFRESH_DIV clk_d cycles.
//  - A conversion starts each time the scan wraps (frame_start) while the
//    converter is idle.
// Optional feature: define LEAD_ZERO_BLANK_EN to blank leading zeros.
//
// state   | meaning
// S_IDLE  | waiting for frame_start
// S_LOAD  | capture the selected input and clear the BCD scratch register
// S_SHIFT | DATA_W double-dabble iterations, one per cycle
// S_DONE  | publish scratch and overflow to the display register
module display_7seg_mux #(
  parameter int N_DIGITS    = 4,
  parameter int DATA_W      = 10,
  parameter int FREQ_W      = 8,
  parameter int REFRESH_DIV = 1
) (
  input  logic                clk_d,
  input  logic                reset,
  input  logic [FREQ_W-1:0]   frecuencia,
  input  logic [DATA_W-1:0]   corriente,
  input  logic                control,
  output logic [6:0]          codificacion,
  output logic [N_DIGITS-1:0] digito,
  output logic                busy
);

  localparam int SCR_W  = 4 * N_DIGITS;
  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCAN_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  // Largest value that fits on the display; anything above shows dashes.
  localparam logic [31:0] MAX_VAL = 32'(10 ** N_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [TICK_W-1:0]   r_tick;
  logic [SCAN_W-1:0]   r_scan;
  logic [DATA_W-1:0]   r_bin;
  logic [SCR_W-1:0]    r_bcd;
  logic [SCR_W-1:0]    r_disp;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_scr;
  logic                r_ovf;
  logic [6:0]          r_seg;
  logic [N_DIGITS-1:0] r_dig;

  logic                w_tick_tc;
  logic                w_frame_start;
  logic [DATA_W-1:0]   w_cap;
  logic [SCR_W-1:0]    w_bcd_adj;
  logic [3:0]          w_nib;
  logic                w_blank;
  logic [6:0]          w_seg;
  logic                w_load, w_shift, w_done;

  assign w_tick_tc     = (r_tick == TICK_W'(REFRESH_DIV - 1));
  assign w_frame_start = w_tick_tc && (r_scan == SCAN_W'(N_DIGITS - 1));
  assign w_cap         = control ? DATA_W'(frecuencia) : corriente;

  // Refresh tick counter and scan index.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
      r_scan <= '0;
    end else if (w_tick_tc) begin
      r_tick <= '0;
      r_scan <= (r_scan == SCAN_W'(N_DIGITS - 1)) ? '0 : r_scan + 1'b1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic; frame_start outside IDLE is dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_load  = (r_state == S_LOAD);
    w_shift = (r_state == S_SHIFT);
    w_done  = (r_state == S_DONE);
    busy    = (r_state != S_IDLE);
  end

  // Double-dabble correction: add 3 to every nibble >= 5 before shifting.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath; the display register changes only in DONE.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_scr <= 1'b0;
      r_disp    <= '0;
      r_ovf     <= 1'b0;
    end else if (w_load) begin
      r_bin     <= w_cap;
      r_bcd     <= '0;
      r_cnt     <= CNT_W'(DATA_W - 1);
      r_ovf_scr <= (32'(w_cap) > MAX_VAL);
    end else if (w_shift) begin
      r_bcd <= {w_bcd_adj[SCR_W-2:0], r_bin[DATA_W-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 1'b1;
    end else if (w_done) begin
      r_disp <= r_bcd;
      r_ovf  <= r_ovf_scr;
    end
  end

  // Select the current digit's nibble and decide leading-zero blanking.
  always_comb begin
    w_nib   = '0;
    w_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_scan == SCAN_W'(i)) begin
        w_nib = r_disp[4*i +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        if (i > 0 && (r_disp >> (4 * i)) == '0) w_blank = 1'b1;
`endif
      end
    end
  end

  // Active-low segment decode {a,b,c,d,e,f,g}; dashes override blanking.
  always_comb begin
    case (w_nib)
      4'd0:    w_seg = 7'b0000001;
      4'd1:    w_seg = 7'b1001111;
      4'd2:    w_seg = 7'b0010010;
      4'd3:    w_seg = 7'b0000110;
      4'd4:    w_seg = 7'b1001100;
      4'd5:    w_seg = 7'b0100100;
      4'd6:    w_seg = 7'b0100000;
      4'd7:    w_seg = 7'b0001111;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0000100;
      default: w_seg = 7'b1111111;
    endcase
    if (w_blank) w_seg = 7'b1111111;
    if (r_ovf)   w_seg = 7'b1111110;
  end

  // Registered panel outputs, both derived from the same scan index.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_seg <= 7'b1111111;
      r_dig <= N_DIGITS'(1);
    end else begin
      r_seg <= w_seg;
      r_dig <= N_DIGITS'(1) << r_scan;
    end
  end

  assign codificacion = r_seg;
  assign digito       = r_dig;

endmodule
